// File: rtl/wb_seq_ctrl.sv
// Registered multi-beat writeback sequencer for the register-file write port.
// Optional macro WB_PC_FLUSH_EN adds a registered PC_FLUSH output for PC-write beats.
module wb_seq_ctrl #(
  parameter int NREG   = 16,
  parameter int RA_W   = 4,
  parameter int PC_IDX = 15
) (
  input  logic            CLK,
  input  logic            RST_n,
  input  logic            VALID,
  output logic            READY,
  input  logic [31:0]     OPCODE,
  input  logic [3:0]      DEC,
  output logic            WB_FWD_SEL,
  output logic            REG_WDAT_SEL,
  output logic            REG_W,
  output logic [RA_W-1:0] REG_WADDR,
  output logic            BUSY,
  output logic [2:0]      DBG_STATE
`ifdef WB_PC_FLUSH_EN
  ,
  output logic            PC_FLUSH
`endif
);

  // Handshake: an instruction is taken on a rising edge where VALID & READY.
  // READY is high when idle or while the last beat of the current sequence
  // is on the outputs, so a new instruction can follow with no bubble.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SINGLE = 3'd1,
    S_LDDATA = 3'd2,
    S_BASE   = 3'd3,
    S_BLK    = 3'd4
  } state_e;

  localparam logic [RA_W-1:0] PC_ADDR = RA_W'(PC_IDX);

  state_e            state_q, state_d;
  logic              fwd_q, fwd_d, wdat_q, wdat_d, w_q, w_d;
  logic [RA_W-1:0]   waddr_q, waddr_d, rn_q, rn_d;
  logic [NREG-1:0]   list_q, list_d;
  logic              base_q, base_d, blk_ld_q, blk_ld_d;
  logic              last_beat, ready;

  logic              op_l, op_w, op_p, base_wb;
  logic [RA_W-1:0]   op_rd, op_rn;
  logic [NREG-1:0]   op_list;
  logic              unused_opcode;

  assign op_l          = OPCODE[20];
  assign op_w          = OPCODE[21];
  assign op_p          = OPCODE[24];
  assign op_rd         = OPCODE[12 +: RA_W];
  assign op_rn         = OPCODE[16 +: RA_W];
  assign op_list       = OPCODE[NREG-1:0];
  assign base_wb       = op_w | ~op_p;
  assign unused_opcode = ^{OPCODE[31:25], OPCODE[23:22]};

  function automatic logic [RA_W-1:0] lowest_idx(input logic [NREG-1:0] v);
    lowest_idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = RA_W'(i);
    end
  endfunction

  always_comb begin
    state_d  = state_q;
    fwd_d    = 1'b0;
    wdat_d   = 1'b0;
    w_d      = 1'b0;
    waddr_d  = waddr_q;
    rn_d     = rn_q;
    list_d   = list_q;
    base_d   = base_q;
    blk_ld_d = blk_ld_q;

    case (state_q)
      S_LDDATA: last_beat = ~base_q;
      S_BLK:    last_beat = (list_q == '0) && !base_q;
      default:  last_beat = 1'b1;
    endcase
    ready = (state_q == S_IDLE) || last_beat;

    if (!ready) begin
      // Mid-sequence: either the next list register or the base writeback.
      if (state_q == S_BLK && list_q != '0) begin
        fwd_d   = blk_ld_q;
        wdat_d  = blk_ld_q;
        w_d     = blk_ld_q;
        waddr_d = lowest_idx(list_q);
        list_d  = list_q & (list_q - NREG'(1));
      end else begin
        state_d = S_BASE;
        w_d     = 1'b1;
        waddr_d = rn_q;
        base_d  = 1'b0;
      end
    end else if (VALID) begin
      base_d = 1'b0;
      list_d = '0;
      case (DEC)
        4'd1, 4'd2, 4'd7, 4'd11: begin
          state_d = S_SINGLE;
          w_d     = 1'b1;
          waddr_d = op_rd;
        end
        4'd3: begin
          state_d = S_SINGLE;
          fwd_d   = 1'b1;
          wdat_d  = 1'b1;
          w_d     = 1'b1;
          waddr_d = op_rd;
        end
        4'd6, 4'd8: begin
          if (!op_l) begin
            state_d = base_wb ? S_BASE : S_SINGLE;
            w_d     = base_wb;
            waddr_d = op_rn;
          end else begin
            state_d = S_LDDATA;
            fwd_d   = 1'b1;
            wdat_d  = 1'b1;
            w_d     = 1'b1;
            waddr_d = op_rd;
            rn_d    = op_rn;
            base_d  = base_wb && (op_rd != op_rn);
          end
        end
        4'd9: begin
          state_d  = S_BLK;
          rn_d     = op_rn;
          blk_ld_d = op_l;
          // A loaded base register keeps the memory value over the writeback.
          base_d   = op_w && !(op_l && op_list[op_rn]);
          if (op_list != '0) begin
            fwd_d   = op_l;
            wdat_d  = op_l;
            w_d     = op_l;
            waddr_d = lowest_idx(op_list);
            list_d  = op_list & (op_list - NREG'(1));
          end
        end
        default: state_d = S_SINGLE;
      endcase
    end else begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q  <= S_IDLE;
      fwd_q    <= 1'b0;
      wdat_q   <= 1'b0;
      w_q      <= 1'b0;
      waddr_q  <= '0;
      rn_q     <= '0;
      list_q   <= '0;
      base_q   <= 1'b0;
      blk_ld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fwd_q    <= fwd_d;
      wdat_q   <= wdat_d;
      w_q      <= w_d;
      waddr_q  <= waddr_d;
      rn_q     <= rn_d;
      list_q   <= list_d;
      base_q   <= base_d;
      blk_ld_q <= blk_ld_d;
    end
  end

`ifdef WB_PC_FLUSH_EN
  logic pc_flush_q;
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) pc_flush_q <= 1'b0;
    else        pc_flush_q <= w_d && (waddr_d == PC_ADDR);
  end
  assign PC_FLUSH = pc_flush_q;
`else
  logic unused_pc_addr;
  assign unused_pc_addr = ^PC_ADDR;
`endif

  assign READY        = ready;
  assign BUSY         = (state_q != S_IDLE);
  assign DBG_STATE    = state_q;
  assign WB_FWD_SEL   = fwd_q;
  assign REG_WDAT_SEL = wdat_q;
  assign REG_W        = w_q;
  assign REG_WADDR    = waddr_q;

endmodule

// File: tb/tb_wb_seq_ctrl.sv
// Bench for wb_seq_ctrl: directed scenarios plus randomized instruction streams
// checked beat-by-beat against a list-based model of the writeback rules.
module tb_wb_seq_ctrl;

  logic        CLK, RST_n, VALID, READY, BUSY;
  logic [31:0] OPCODE;
  logic [3:0]  DEC, REG_WADDR;
  logic        WB_FWD_SEL, REG_WDAT_SEL, REG_W;
  logic [2:0]  DBG_STATE;
`ifdef WB_PC_FLUSH_EN
  logic        PC_FLUSH;
`endif

  int total = 0;
  int bad   = 0;
  logic mon_en = 1'b0;
  // Entry: {last, fwd, wdat, w, addr_checked, addr[3:0]}
  logic [8:0] exp_q[$];
  logic [8:0] e;

  wb_seq_ctrl dut (
    .CLK(CLK), .RST_n(RST_n), .VALID(VALID), .READY(READY),
    .OPCODE(OPCODE), .DEC(DEC), .WB_FWD_SEL(WB_FWD_SEL),
    .REG_WDAT_SEL(REG_WDAT_SEL), .REG_W(REG_W), .REG_WADDR(REG_WADDR),
    .BUSY(BUSY), .DBG_STATE(DBG_STATE)
`ifdef WB_PC_FLUSH_EN
    , .PC_FLUSH(PC_FLUSH)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // Reference model: expand one instruction into its list of beats.
  task automatic model_push(input logic [3:0] dec, input logic [31:0] op);
    logic [7:0] b[$];
    logic l, w, p, bwb;
    logic [3:0] rd, rn;
    l = op[20]; w = op[21]; p = op[24];
    rd = op[15:12]; rn = op[19:16];
    bwb = w | ~p;
    case (dec)
      4'd1, 4'd2, 4'd7, 4'd11: b.push_back({3'b001, 1'b1, rd});
      4'd3: b.push_back({3'b111, 1'b1, rd});
      4'd6, 4'd8: begin
        if (!l) b.push_back({2'b00, bwb, 1'b1, rn});
        else begin
          b.push_back({3'b111, 1'b1, rd});
          if (bwb && rd != rn) b.push_back({3'b001, 1'b1, rn});
        end
      end
      4'd9: begin
        for (int i = 0; i < 16; i++)
          if (op[i]) b.push_back({l, l, l, 1'b1, 4'(i)});
        if (b.size() == 0) b.push_back(8'b0);
        if (w && !(l && op[rn])) b.push_back({3'b001, 1'b1, rn});
      end
      default: b.push_back(8'b0);
    endcase
    for (int i = 0; i < b.size(); i++)
      exp_q.push_back({(i == b.size() - 1), b[i]});
  endtask

  // Scoreboard monitor: every busy cycle consumes one expected beat.
  always @(negedge CLK) begin
    if (RST_n && mon_en) begin
      if (BUSY) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_beat ctrl=%b addr=%0d exp=no beat", {WB_FWD_SEL, REG_WDAT_SEL, REG_W}, REG_WADDR);
        end else begin
          e = exp_q.pop_front();
          if ({WB_FWD_SEL, REG_WDAT_SEL, REG_W} !== e[7:5]) begin
            bad++;
            $display("FAIL beat_ctrl got=%b exp=%b", {WB_FWD_SEL, REG_WDAT_SEL, REG_W}, e[7:5]);
          end
          if (e[4]) begin
            total++;
            if (REG_WADDR !== e[3:0]) begin
              bad++;
              $display("FAIL beat_addr got=%0d exp=%0d", REG_WADDR, e[3:0]);
            end
          end
          total++;
          if (READY !== e[8]) begin
            bad++;
            $display("FAIL beat_ready got=%b exp=%b", READY, e[8]);
          end
`ifdef WB_PC_FLUSH_EN
          total++;
          if (PC_FLUSH !== (e[5] && e[3:0] == 4'd15)) begin
            bad++;
            $display("FAIL pc_flush got=%b exp=%b", PC_FLUSH, (e[5] && e[3:0] == 4'd15));
          end
`endif
        end
      end else begin
        total++;
        if ({WB_FWD_SEL, REG_WDAT_SEL, REG_W} !== 3'b000 || READY !== 1'b1) begin
          bad++;
          $display("FAIL idle_outputs ctrl=%b ready=%b exp ctrl=000 ready=1", {WB_FWD_SEL, REG_WDAT_SEL, REG_W}, READY);
        end
        total++;
        if (exp_q.size() != 0) begin
          bad++;
          $display("FAIL missing_beat pending=%0d exp=0", exp_q.size());
        end
      end
    end
  end

  // Driver: present an instruction, hold VALID until taken, then drop it.
  task automatic send(input logic [3:0] dec, input logic [31:0] op);
    int n;
    n = 0;
    VALID = 1'b1; DEC = dec; OPCODE = op;
    while (READY !== 1'b1 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    total++;
    if (READY !== 1'b1) begin
      bad++;
      $display("FAIL send_ready got=%b exp=1", READY);
      VALID = 1'b0;
      return;
    end
    @(posedge CLK);
    model_push(dec, op);
    @(negedge CLK);
    VALID = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge CLK);
    repeat (2) @(negedge CLK);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  function automatic logic [31:0] mk(input logic p, input logic w, input logic l,
                                     input logic [3:0] rn, input logic [3:0] rd,
                                     input logic [11:0] lo);
    mk = {7'b0, p, 2'b0, w, l, rn, rd, lo};
  endfunction

  task automatic test_reset();
    RST_n = 1'b0; VALID = 1'b1; DEC = 4'd1; OPCODE = 32'h0000_5000;
    repeat (3) @(negedge CLK);
    total++;
    if (READY !== 1'b1 || BUSY !== 1'b0) begin
      bad++;
      $display("FAIL reset_hs ready=%b busy=%b exp ready=1 busy=0", READY, BUSY);
    end
    total++;
    if ({WB_FWD_SEL, REG_WDAT_SEL, REG_W, REG_WADDR} !== 7'b0) begin
      bad++;
      $display("FAIL reset_outs got=%b exp=0", {WB_FWD_SEL, REG_WDAT_SEL, REG_W, REG_WADDR});
    end
    VALID = 1'b0;
    RST_n = 1'b1;
    mon_en = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_alu_back_to_back();
    send(4'd1, mk(0, 0, 0, 4'd0, 4'd3, 12'h0));
    send(4'd1, mk(0, 0, 0, 4'd0, 4'd5, 12'h0));
    send(4'd3, mk(0, 0, 0, 4'd0, 4'd9, 12'h0));
    drain();
  endtask

  task automatic test_load_post_index();
    send(4'd6, mk(0, 0, 1, 4'd4, 4'd2, 12'h0));
    drain();
    send(4'd6, mk(0, 0, 1, 4'd4, 4'd4, 12'h0));
    drain();
  endtask

  task automatic test_ldm_writeback();
    send(4'd9, mk(0, 1, 1, 4'd13, 4'h8, 12'h005));
    drain();
  endtask

  task automatic test_empty_and_suppressed();
    send(4'd9, mk(0, 1, 0, 4'd1, 4'h0, 12'h000));
    send(4'd9, mk(0, 1, 1, 4'd1, 4'h0, 12'h002));
    drain();
  endtask

  task automatic test_store_and_ignore();
    int n;
    send(4'd8, mk(1, 0, 0, 4'd7, 4'd2, 12'h0));
    drain();
    send(4'd9, mk(0, 0, 1, 4'd3, 4'h0, 12'h0F0));
    n = 0;
    while (READY !== 1'b1 && n < 50) begin
      VALID = 1'b1; DEC = 4'd1; OPCODE = $urandom();
      @(negedge CLK);
      n++;
    end
    VALID = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid_ldm();
    send(4'd9, mk(0, 0, 1, 4'd3, 4'h0, 12'h0F0));
    @(negedge CLK);
    #1;
    RST_n = 1'b0;
    #1;
    total++;
    if ({WB_FWD_SEL, REG_WDAT_SEL, REG_W} !== 3'b000 || READY !== 1'b1 || BUSY !== 1'b0) begin
      bad++;
      $display("FAIL async_reset ctrl=%b ready=%b busy=%b exp 000/1/0", {WB_FWD_SEL, REG_WDAT_SEL, REG_W}, READY, BUSY);
    end
    exp_q.delete();
    @(negedge CLK);
    RST_n = 1'b1;
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_random();
    logic [3:0] decs[16];
    logic [31:0] op;
    decs = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd8, 4'd9, 4'd10,
             4'd7, 4'd11, 4'd4, 4'd5, 4'd12, 4'd6, 4'd9, 4'd8};
    for (int k = 0; k < 80; k++) begin
      op = $urandom();
      if ($urandom_range(0, 1) == 1) op[15:0] = op[15:0] & 16'($urandom());
      send(decs[$urandom_range(0, 15)], op);
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_alu_back_to_back();
    test_load_post_index();
    test_ldm_writeback();
    test_empty_and_suppressed();
    test_store_and_ignore();
    test_reset_mid_ldm();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
